// File: rtl/pfft_norm_pkg.sv
// Shared widths, types and stage payload for the posit FFT product normaliser.
package pfft_norm_pkg;

  localparam int unsigned PROD_W  = 61;
  localparam int unsigned FRAC_W  = 57;
  localparam int unsigned LZC_W   = 6;
  localparam int unsigned GRD_BIT = PROD_W - FRAC_W - 1;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [FRAC_W-1:0] frac_t;
  typedef logic [LZC_W-1:0]  lzc_t;

  typedef struct packed {
    prod_t data;
    lzc_t  lz;
    logic  zero;
    logic  valid;
  } stage_t;

endpackage

// File: rtl/pfft_lzc61.sv
// Combinational leading-zero counter for the 61-bit product, built as a
// log-depth tree of 2:1 priority merges over a 64-bit padded vector.
module pfft_lzc61
  import pfft_norm_pkg::*;
(
  input  prod_t data_i,
  output lzc_t  lzc_o
);

  // Low pad bits are ones so an all-zero product counts to exactly PROD_W.
  localparam int unsigned PAD_W = 64 - PROD_W;

  logic [63:0] v [0:6];
  lzc_t        c [0:6][0:63];

  always_comb begin
    for (int unsigned l = 0; l <= 6; l++) begin
      v[l] = '0;
      for (int unsigned i = 0; i < 64; i++) c[l][i] = '0;
    end
    v[0] = {data_i, {PAD_W{1'b1}}};
    for (int unsigned l = 0; l < 6; l++) begin
      for (int unsigned i = 0; i < (64 >> (l + 1)); i++) begin
        v[l+1][i] = v[l][2*i+1] | v[l][2*i];
        c[l+1][i] = v[l][2*i+1] ? c[l][2*i+1] : (c[l][2*i] | (lzc_t'(1) << l));
      end
    end
  end

  assign lzc_o = c[6][0];

endmodule

// File: rtl/pfft_prod_normalize.sv
// Three-stage normalise/round pipeline for the mantissa product.
// PFFT_NORM_RNE_EN selects round-to-nearest-even; undefined truncates.
module pfft_prod_normalize
  import pfft_norm_pkg::*;
(
  input  logic  ap_clk,
  input  logic  ap_rst,
  input  prod_t in_data,
  input  logic  in_valid,
  output logic  in_ready,
  output frac_t out_frac,
  output lzc_t  out_lzc,
  output logic  out_carry,
  output logic  out_zero,
  output logic  out_inexact,
  output logic  out_valid,
  input  logic  out_ready
);

  logic   en;
  lzc_t   lz1;
  stage_t s1_d, s1_q, s2_d, s2_q;

  frac_t  frac_raw, frac_d, out_frac_q;
  logic   guard, sticky, up, carry_d, inexact_d;
  logic   [FRAC_W:0] sum;
  lzc_t   out_lzc_q;
  logic   out_carry_q, out_zero_q, out_inexact_q, out_valid_q;

  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;

  pfft_lzc61 u_lzc (
    .data_i (in_data),
    .lzc_o  (lz1)
  );

  always_comb begin
    s1_d.data  = in_data;
    s1_d.lz    = lz1;
    s1_d.zero  = (in_data == '0);
    s1_d.valid = in_valid;

    s2_d       = s1_q;
    s2_d.data  = s1_q.data << s1_q.lz;
  end

  always_comb begin
    frac_raw  = s2_q.data[PROD_W-1 -: FRAC_W];
    guard     = s2_q.data[GRD_BIT];
    sticky    = |s2_q.data[GRD_BIT-1:0];
    inexact_d = guard | sticky;
`ifdef PFFT_NORM_RNE_EN
    up        = guard & (sticky | frac_raw[0]);
`else
    up        = 1'b0;
`endif
    sum       = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, up};
`ifdef PFFT_NORM_RNE_EN
    carry_d   = sum[FRAC_W];
`else
    carry_d   = 1'b0;
`endif
    frac_d    = carry_d ? {1'b1, {(FRAC_W-1){1'b0}}} : sum[FRAC_W-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      out_frac_q    <= '0;
      out_lzc_q     <= '0;
      out_carry_q   <= 1'b0;
      out_zero_q    <= 1'b0;
      out_inexact_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else if (en) begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      out_frac_q    <= frac_d;
      out_lzc_q     <= s2_q.lz;
      out_carry_q   <= carry_d;
      out_zero_q    <= s2_q.zero;
      out_inexact_q <= inexact_d;
      out_valid_q   <= s2_q.valid;
    end
  end

  assign out_frac    = out_frac_q;
  assign out_lzc     = out_lzc_q;
  assign out_carry   = out_carry_q;
  assign out_zero    = out_zero_q;
  assign out_inexact = out_inexact_q;
  assign out_valid   = out_valid_q;

endmodule

// File: doc/pfft_prod_normalize.md
# pfft_prod_normalize

Normalisation and rounding stage directly downstream of the 57×4-bit unsigned mantissa multiplier in the posit FFT datapath. It takes the raw 61-bit unsigned product, counts leading zeros, shifts the leading one to the MSB, and rounds to a 57-bit fraction. It also reports the shift amount, a rounding carry and an inexact flag so the posit encoder can rebuild the exponent/regime. The stage is a 3-deep valid/ready pipeline with full-throughput backpressure.

## Interface
- PROD_W, 61, product width (input)
- FRAC_W, 57, output fraction width, hidden bit at MSB; PROD_W − FRAC_W ≥ 2 (guard + ≥1 sticky bit)
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- in_data  in  PROD_W  unsigned product
- in_valid  in  1  input qualifier
- in_ready  out  1  stage accepts in_data this cycle
- out_frac  out  FRAC_W  normalised, rounded fraction (MSB = 1 unless out_zero)
- out_lzc  out  6  leading-zero count of in_data, 0..PROD_W
- out_carry  out  1  rounding overflowed; out_frac = 1<<(FRAC_W−1)
- out_zero  out  1  in_data was 0
- out_inexact  out  1  any discarded bit was 1
- out_valid  out  1  outputs valid
- out_ready  in  1  downstream accepts

## Operation
- S1: register in_data; compute lz = leading zeros (lz = PROD_W and zero = 1 when in_data = 0).
- S2: sh = in_data << lz; frac = sh[PROD_W−1 : PROD_W−FRAC_W]; guard = sh[PROD_W−FRAC_W−1]; sticky = OR of the remaining lower bits.
- S3: round-to-nearest-even: up = guard & (sticky | frac[0]); frac += up. Carry out of the MSB: out_frac = 1<<(FRAC_W−1), out_carry = 1. out_lzc is never modified by rounding.
- out_inexact = guard | sticky, independent of the rounding mode.
- Zero input: out_frac = 0, out_lzc = PROD_W, out_zero = 1, carry = inexact = 0.
- Downstream exponent contribution = (PROD_W−1) − out_lzc + out_carry; this stage performs no exponent arithmetic.

## Timing
- Latency 3 cycles from accepted input to out_valid with out_ready held high; throughput 1 item per cycle.
- Global enable en = out_ready | ~out_valid. All three stages advance together on en. in_ready = en (combinational). Bubbles are not collapsed.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- While out_valid & ~out_ready: every output and every stage register holds. No loss, no duplication.
- Reset: all stage valid bits and out_valid = 0. out_frac, out_lzc, out_carry, out_zero, out_inexact = 0. in_ready = 1 in the first cycle after reset.
- Reset asserted mid-stream: all in-flight items are discarded. The cycle after reset shows out_valid = 0.

## Configuration
- PFFT_NORM_RNE_EN defined: round-to-nearest-even as above.
- PFFT_NORM_RNE_EN undefined: truncation. up = 0, out_carry is tied to 0, and out_inexact is still reported.
- Latency and handshake are identical in both builds.

## Structure
- Package pfft_norm_pkg holds:
  - constants PROD_W = 61, FRAC_W = 57, LZC_W = 6
  - typedefs prod_t, frac_t, lzc_t
  - a stage-payload struct (data, lz, zero, valid)
- Sub-module pfft_lzc61: combinational leading-zero counter, PROD_W in, LZC_W out, tree of 2:1 priority merges, instantiated in S1.

## Test plan
- in_data = 1<<60 → after 3 cycles out_frac = 1<<56, out_lzc = 0, carry = 0, inexact = 0.
- in_data = 1 → out_frac = 1<<56, out_lzc = 60, inexact = 0. Then in_data = 0 → out_zero = 1, out_frac = 0, out_lzc = 61.
- in_data = 61'h1FFF_FFFF_FFFF_FFFF → RNE build: out_frac = 1<<56, out_carry = 1, inexact = 1, out_lzc = 0. Truncation build: out_frac = all ones, carry = 0, inexact = 1.
- Tie cases:
  - (1<<60)|(1<<3) → out_frac = 1<<56 (round to even, no increment), inexact = 1.
  - (1<<60)|(1<<4)|(1<<3) → out_frac = (1<<56)|2.
- Back-to-back stream of values 1..8 with out_ready low for 4 cycles after the 2nd output → outputs appear in order, exactly once, and are held stable during the stall. in_ready = 0 while the pipe is full and stalled.
- ap_rst pulsed while 3 items are in flight → next cycle out_valid = 0 and all outputs 0. A fresh input then appears 3 cycles after acceptance.
